muldiv_unit: RTL and testbench

- Iterative 32-bit unsigned multiply/divide execution unit.
- Sits directly downstream of the register file's BusA/BusB read ports and feeds its write port (Data_in/DR/RW), giving writeback for long-latency arithmetic.
- Uses a fixed-latency shift-add multiply and restoring divide, one bit per clock, with a start/busy/done handshake.

---
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_unit.sv | 115 +++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and operand/result bundle between the register file and muldiv_unit.
// The master drives the request; the slave (the unit) returns the writeback.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic [4:0]       DR_in;
    logic             busy;
    logic             done;
    logic             RW;
    logic [4:0]       DR;
    logic [WIDTH-1:0] Data_out;

    modport master (
        output start, op, BusA, BusB, DR_in,
        input  busy, done, RW, DR, Data_out
    );

    modport slave (
        input  start, op, BusA, BusB, DR_in,
        output busy, done, RW, DR, Data_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply, restoring divide,
// one bit per clock, fixed 33-cycle latency with a registered writeback pulse.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           op_q;
    logic [4:0]           dr_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 busy_q;
    logic                 done_q;
    logic [4:0]           dr_out_q;
    logic [WIDTH-1:0]     data_q;

    logic [WIDTH-1:0]     mul_add;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_part;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     a_step;
    logic [WIDTH-1:0]     b_step;

    // acc holds {product_hi, product_lo} for multiply, {remainder, quotient} for divide.
    always_comb begin
        mul_add   = b_q[0] ? a_q : '0;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        div_part  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_trial = div_part - {1'b0, b_q};
        acc_step  = acc_q;
        a_step    = a_q;
        b_step    = b_q;
        if (!op_q[1]) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
            b_step   = b_q >> 1;
        end else begin
            a_step = a_q << 1;
            if (!div_trial[WIDTH]) begin
                acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            dr_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dr_out_q <= '0;
            data_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.BusA;
                        b_q     <= bus.BusB;
                        op_q    <= bus.op;
                        dr_q    <= bus.DR_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_step;
                    a_q   <= a_step;
                    b_q   <= b_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    unique case (op_q)
                        2'b00: data_q <= acc_q[WIDTH-1:0];
                        2'b01: data_q <= acc_q[2*WIDTH-1:WIDTH];
                        2'b10: data_q <= acc_q[WIDTH-1:0];
                        2'b11: data_q <= acc_q[2*WIDTH-1:WIDTH];
                        default: data_q <= '0;
                    endcase
                    dr_out_q <= dr_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.RW       = done_q;
    assign bus.DR       = dr_out_q;
    assign bus.Data_out = data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, handshake corner cases.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drives one request at the current negedge; returns once done is seen (or bound expires).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input int inject_at, input int rst_at,
                          output int lat, output int nbusy);
        bus.start = 1'b1;
        bus.op    = o;
        bus.BusA  = a;
        bus.BusB  = b;
        bus.DR_in = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.BusA  = ~a;
        bus.BusB  = b ^ 32'h5a5a_5a5a;
        bus.DR_in = ~d;
        lat   = -1;
        nbusy = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rst       = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) nbusy++;
            if (k == inject_at) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
                bus.BusA  = 32'd999;
                bus.BusB  = 32'd3;
                bus.DR_in = 5'd30;
            end
            if (k == rst_at) rst = 1'b1;
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.BusA = '0;
        bus.BusB = '0;
        bus.DR_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.RW !== 1'b0 ||
                bus.Data_out !== 32'h0 || bus.DR !== 5'h0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_idle: %0d cycles with nonzero outputs, required 0", bad);
        end
    endtask

    task automatic test_mul();
        int lat, nb;
        run_op(2'b00, 32'h0000_1234, 32'h0000_5678, 5'd7, -1, -1, lat, nb);
        n_cmp++;
        if (lat !== 33) begin n_err++; $display("FAIL mul_latency: got %0d required 33", lat); end
        n_cmp++;
        if (nb !== 33) begin n_err++; $display("FAIL mul_busy_cycles: got %0d required 33", nb); end
        n_cmp++;
        if (bus.Data_out !== 32'h0626_0060) begin
            n_err++; $display("FAIL mul_data: got %h required 06260060", bus.Data_out);
        end
        n_cmp++;
        if (bus.DR !== 5'd7 || bus.RW !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_writeback: DR=%0d RW=%b busy=%b required 7 1 0",
                     bus.DR, bus.RW, bus.busy);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0 || bus.RW !== 1'b0 || bus.Data_out !== 32'h0626_0060 ||
            bus.DR !== 5'd7) begin
            n_err++;
            $display("FAIL mul_hold: done=%b RW=%b data=%h DR=%0d required 0 0 06260060 7",
                     bus.done, bus.RW, bus.Data_out, bus.DR);
        end
    endtask

    task automatic test_mulhu();
        int lat, nb;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, -1, -1, lat, nb);
        n_cmp++;
        if (lat !== 33 || bus.Data_out !== 32'hFFFF_FFFE || bus.DR !== 5'd3) begin
            n_err++;
            $display("FAIL mulhu_max: lat=%0d data=%h DR=%0d required 33 fffffffe 3",
                     lat, bus.Data_out, bus.DR);
        end
        @(negedge clk);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, -1, -1, lat, nb);
        n_cmp++;
        if (lat !== 33 || bus.Data_out !== 32'h0000_0001 || bus.DR !== 5'd0) begin
            n_err++;
            $display("FAIL mul_max_lo: lat=%0d data=%h DR=%0d required 33 00000001 0",
                     lat, bus.Data_out, bus.DR);
        end
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat, nb;
        run_op(2'b10, 32'd100, 32'd7, 5'd12, -1, -1, lat, nb);
        n_cmp++;
        if (lat !== 33 || bus.Data_out !== 32'd14 || bus.DR !== 5'd12) begin
            n_err++;
            $display("FAIL divu_100_7: lat=%0d data=%0d DR=%0d required 33 14 12",
                     lat, bus.Data_out, bus.DR);
        end
        @(negedge clk);
        run_op(2'b11, 32'd100, 32'd7, 5'd13, -1, -1, lat, nb);
        n_cmp++;
        if (lat !== 33 || bus.Data_out !== 32'd2 || bus.DR !== 5'd13) begin
            n_err++;
            $display("FAIL remu_100_7: lat=%0d data=%0d DR=%0d required 33 2 13",
                     lat, bus.Data_out, bus.DR);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, nb;
        run_op(2'b10, 32'h1234_5678, 32'h0, 5'd1, -1, -1, lat, nb);
        n_cmp++;
        if (lat !== 33 || bus.Data_out !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL divu_by_zero: lat=%0d data=%h required 33 ffffffff", lat, bus.Data_out);
        end
        @(negedge clk);
        run_op(2'b11, 32'h1234_5678, 32'h0, 5'd2, -1, -1, lat, nb);
        n_cmp++;
        if (lat !== 33 || bus.Data_out !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL remu_by_zero: lat=%0d data=%h required 33 12345678", lat, bus.Data_out);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int lat, nb;
        run_op(2'b00, 32'h0000_1234, 32'h0000_5678, 5'd9, 10, -1, lat, nb);
        n_cmp++;
        if (lat !== 33 || bus.Data_out !== 32'h0626_0060 || bus.DR !== 5'd9) begin
            n_err++;
            $display("FAIL start_mid_run: lat=%0d data=%h DR=%0d required 33 06260060 9",
                     lat, bus.Data_out, bus.DR);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL start_mid_run_idle: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, nb;
        run_op(2'b10, 32'd1000, 32'd10, 5'd4, -1, -1, lat1, nb);
        n_cmp++;
        if (lat1 !== 33 || bus.Data_out !== 32'd100) begin
            n_err++;
            $display("FAIL b2b_first: lat=%0d data=%0d required 33 100", lat1, bus.Data_out);
        end
        // Second request issued in the done cycle; its done is 34 cycles after the first.
        run_op(2'b11, 32'd1000, 32'd7, 5'd5, -1, -1, lat2, nb);
        n_cmp++;
        if (lat2 !== 33 || bus.Data_out !== 32'd6 || bus.DR !== 5'd5) begin
            n_err++;
            $display("FAIL b2b_second: lat=%0d data=%0d DR=%0d required 33 6 5",
                     lat2, bus.Data_out, bus.DR);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, nb;
        run_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21, -1, 10, lat, nb);
        n_cmp++;
        if (lat !== -1) begin
            n_err++; $display("FAIL reset_mid_no_done: done seen at %0d required none", lat);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.RW !== 1'b0 || bus.Data_out !== 32'h0 || bus.DR !== 5'h0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: busy=%b RW=%b data=%h DR=%0d required all 0",
                     bus.busy, bus.RW, bus.Data_out, bus.DR);
        end
        rst = 1'b1;
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.BusA = 32'd5;
        bus.BusB = 32'd5;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL reset_and_start: busy=%b required 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulhu();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
